peak_counter_ctrl: RTL and testbench

PEAK_COUNTER_CTRL -- requirements
Module: peak_counter_ctrl

---
 rtl/peak_counter_ctrl.sv | 154 +++++++++++++++
 tb/tb_peak_counter_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/peak_counter_ctrl.sv
// Frame controller for a bank of channel counters: gates counting, loads the
// datapath shift register and streams CNTR_DEPTH words to a host FIFO.
module peak_counter_ctrl #(
  parameter int CNTR_WIDTH = 8,
  parameter int CNTR_DEPTH = 24,
  parameter int GATE_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [GATE_W-1:0]     gate_len,
  output logic                  counter_clk_en,
  output logic                  sreg_load_en,
  output logic                  sreg_shift_en,
  input  logic [CNTR_WIDTH-1:0] count_out,
  input  logic                  count_vld_out,
  input  logic [CNTR_DEPTH-1:0] overflow_out,
  output logic [CNTR_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNTR_DEPTH-1:0] ovf_flags,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (CNTR_DEPTH > 1) ? $clog2(CNTR_DEPTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CNTR_DEPTH - 1);
  localparam logic [GATE_W-1:0] G_ZERO   = GATE_W'(0);
  localparam logic [GATE_W-1:0] G_ONE    = GATE_W'(1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [GATE_W-1:0]     timer;
  logic [GATE_W-1:0]     timer_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [CNTR_DEPTH-1:0] ovf_nxt;
  logic                  accept;

  // A zero gate length still yields a single counting cycle.
  function automatic logic [GATE_W-1:0] gate_init(input logic [GATE_W-1:0] g);
    gate_init = (g == G_ZERO) ? G_ONE : g;
  endfunction

  assign accept        = out_valid & out_ready;
  assign sreg_shift_en = accept;
  assign out_data      = count_out;

  // Next-state, gate timer, word index and overflow capture.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    ovf_nxt   = ovf_flags;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_COUNT;
            timer_nxt = gate_init(gate_len);
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_COUNT: begin
          if (timer <= G_ONE) begin
            state_nxt = S_LOAD;
            timer_nxt = G_ZERO;
          end else begin
            timer_nxt = timer - G_ONE;
          end
        end
        S_LOAD: begin
          if (count_vld_out) begin
            state_nxt = S_SHIFT;
            idx_nxt   = IDX_ZERO;
            ovf_nxt   = overflow_out;
          end else begin
            state_nxt = S_LOAD;
          end
        end
        S_SHIFT: begin
          // The index saturates at the last word; that accept ends the frame.
          if (accept) begin
            if (idx == LAST_IDX) begin
              state_nxt = S_DONE;
            end else begin
              idx_nxt = idx + IDX_ONE;
            end
          end else begin
            state_nxt = S_SHIFT;
          end
        end
        S_DONE: begin
          if (continuous) begin
            state_nxt = S_COUNT;
            timer_nxt = gate_init(gate_len);
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, timer, index and captured overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= G_ZERO;
      idx       <= IDX_ZERO;
      ovf_flags <= {CNTR_DEPTH{1'b0}};
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      ovf_flags <= ovf_nxt;
    end
  end

  // Control outputs are registered from the next state so they change cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_clk_en <= 1'b0;
      sreg_load_en   <= 1'b0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      counter_clk_en <= (state_nxt == S_COUNT);
      sreg_load_en   <= (state_nxt == S_LOAD);
      out_valid      <= (state_nxt == S_SHIFT);
      busy           <= (state_nxt != S_IDLE);
      frame_done     <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_peak_counter_ctrl.sv
// Directed-plus-random bench for peak_counter_ctrl with a stub shift-register datapath.
module tb_peak_counter_ctrl;
  localparam int CW = 8;
  localparam int CD = 24;
  localparam int GW = 24;

  logic          clk = 1'b0;
  logic          rst, start, abort, continuous, out_ready;
  logic [GW-1:0] gate_len;
  logic          counter_clk_en, sreg_load_en, sreg_shift_en, count_vld_out;
  logic          out_valid, busy, frame_done;
  logic [CW-1:0] count_out, out_data;
  logic [CD-1:0] overflow_out, ovf_flags;

  int            checks = 0;
  int            errors = 0;
  int            rdy_mode;
  int            ld_wait;
  logic [CW-1:0] frame_words [CD];
  logic [CW-1:0] sreg [CD];
  logic [CD-1:0] ovf_prev;

  always #5 clk = ~clk;

  peak_counter_ctrl #(.CNTR_WIDTH(CW), .CNTR_DEPTH(CD), .GATE_W(GW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .gate_len(gate_len), .counter_clk_en(counter_clk_en), .sreg_load_en(sreg_load_en),
    .sreg_shift_en(sreg_shift_en), .count_out(count_out), .count_vld_out(count_vld_out),
    .overflow_out(overflow_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_flags(ovf_flags), .busy(busy), .frame_done(frame_done)
  );

  assign count_out = sreg[0];

  // Stub datapath: answers a load after a random delay, shifts one word per shift enable.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      count_vld_out <= 1'b0;
      ld_wait       <= 0;
      for (int i = 0; i < CD; i++) sreg[i] <= 8'd0;
    end else if (sreg_load_en) begin
      if (count_vld_out) begin
        count_vld_out <= 1'b0;
        ld_wait       <= $urandom_range(0, 3);
      end else if (ld_wait == 0) begin
        count_vld_out <= 1'b1;
        for (int i = 0; i < CD; i++) sreg[i] <= frame_words[i];
      end else begin
        ld_wait <= ld_wait - 1;
      end
    end else if (sreg_shift_en) begin
      for (int i = 0; i < CD - 1; i++) sreg[i] <= sreg[i+1];
      sreg[CD-1] <= 8'd0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int g);
    @(negedge clk);
    gate_len = GW'(g);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Reference observer: follows frames cycle by cycle and checks them against the frame rules.
  task automatic monitor(input int frames, input int exp_gate, input logic [CD-1:0] ovf_now,
                         input int abort_at);
    int            idx = 0;
    int            ncnt = 0;
    int            done = 0;
    int            cyc = 0;
    int            last_acc = -10;
    int            abort_phase = 0;
    bit            stall = 1'b0;
    bit            finished = 1'b0;
    logic [CW-1:0] held = 8'd0;
    while (!finished) begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_phase == 1) begin
        abort = 1'b1;
        out_ready = 1'b0;
      end else begin
        abort = 1'b0;
      end
      #1;
      cyc++;
      check("exclusive", {62'd0, sreg_load_en & sreg_shift_en,
                          counter_clk_en & (sreg_load_en | sreg_shift_en)}, 64'd0);
      check("shift_en", sreg_shift_en, out_valid & out_ready);
      if (counter_clk_en | sreg_load_en | out_valid | frame_done) check("busy", busy, 1'b1);
      if (abort_phase == 2) begin
        check("abort_idle", {counter_clk_en, sreg_load_en, sreg_shift_en, out_valid, busy,
                             frame_done}, 6'd0);
        check("ovf_retain", ovf_flags, ovf_now);
        ovf_prev = ovf_now;
        finished = 1'b1;
      end else begin
        if (counter_clk_en) begin
          ncnt++;
          check("ovf_hold", ovf_flags, ovf_prev);
        end
        if (sreg_load_en && ncnt > 0) begin
          check("gate_cycles", ncnt, exp_gate);
          ncnt = 0;
        end
        if (stall) begin
          check("valid_hold", out_valid, 1'b1);
          check("stall_stable", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (idx >= CD) begin
            check("extra_word", idx, CD - 1);
          end else begin
            check("word", out_data, frame_words[idx]);
            idx++;
            last_acc = cyc;
          end
          if (idx == abort_at) abort_phase = 1;
        end else if (abort_phase == 1) begin
          abort_phase = 2;
        end
        stall = out_valid && !out_ready;
        held  = out_data;
        if (frame_done) begin
          check("frame_len", idx, CD);
          check("done_timing", cyc, last_acc + 1);
          check("ovf_load", ovf_flags, ovf_now);
          ovf_prev = ovf_now;
          idx = 0;
          done++;
          if (done == frames) finished = 1'b1;
        end
      end
      if (cyc > 5000) begin
        check("timeout", 1'b0, 1'b1);
        finished = 1'b1;
      end
    end
    abort = 1'b0;
  endtask

  task automatic randomize_frame(output logic [CD-1:0] ovf);
    for (int i = 0; i < CD; i++) frame_words[i] = CW'($urandom);
    ovf = CD'($urandom);
  endtask

  initial begin
    logic [CD-1:0] ovf_v;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; out_ready = 1'b0;
    gate_len = 24'd0; overflow_out = 24'd0; rdy_mode = 0; ovf_prev = 24'd0;
    for (int i = 0; i < CD; i++) frame_words[i] = CW'(i + 1);
    #12;
    check("rst_outputs", {counter_clk_en, sreg_load_en, sreg_shift_en, out_valid, busy,
                          frame_done}, 6'd0);
    check("rst_ovf", ovf_flags, 24'd0);
    check("rst_data", out_data, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Words 1..24, always ready, gate of 100, overflow pattern captured at load.
    overflow_out = 24'h800001;
    launch(100);
    monitor(1, 100, 24'h800001, 0);
    @(negedge clk); #1;
    check("idle_after_frame", busy, 1'b0);

    // Toggling back-pressure; previous flags must hold through this COUNT.
    randomize_frame(ovf_v);
    overflow_out = ovf_v;
    rdy_mode = 1;
    launch(7);
    monitor(1, 7, ovf_v, 0);
    @(negedge clk); #1;
    check("idle_after_toggle", busy, 1'b0);

    // Continuous mode with zero gate length: back-to-back frames.
    randomize_frame(ovf_v);
    overflow_out = ovf_v;
    rdy_mode = 2;
    continuous = 1'b1;
    launch(0);
    monitor(3, 1, ovf_v, 0);
    @(negedge clk); #1;
    check("rearm_count", counter_clk_en, 1'b1);
    continuous = 1'b0;
    monitor(1, 1, ovf_v, 0);
    @(negedge clk); #1;
    check("idle_after_cont", busy, 1'b0);

    // Abort after the 10th word.
    randomize_frame(ovf_v);
    overflow_out = ovf_v;
    rdy_mode = 0;
    launch(5);
    monitor(1, 5, ovf_v, 10);

    // Asynchronous reset in the middle of COUNT.
    launch(100);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_enables", {counter_clk_en, sreg_load_en, out_valid, busy, frame_done}, 5'd0);
    check("rst_mid_ovf", ovf_flags, 24'd0);
    ovf_prev = 24'd0;
    @(negedge clk);
    rst = 1'b0;

    // Clean full frame after reset.
    randomize_frame(ovf_v);
    overflow_out = ovf_v;
    rdy_mode = 2;
    launch(30);
    monitor(1, 30, ovf_v, 0);
    @(negedge clk); #1;
    check("idle_final", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
